// File: rtl/xsim_msg_pkg.sv
// Shared types and header field positions for the XSIM message deframer.
// The header-length legality check lives here so the rules stay in one place.
package xsim_msg_pkg;

  typedef struct packed {
    logic        empty;
    logic        first;
    logic        last;
    logic [15:0] method;
    logic [31:0] data;
  } msg_entry_t;

  typedef enum logic {HDR, PAYLOAD} deframe_state_t;

  localparam int HDR_METHOD_MSB = 31;
  localparam int HDR_METHOD_LSB = 16;
  localparam int HDR_LEN_MSB    = 15;

  // Length counts the header itself, so zero can never be a real message.
  function automatic logic len_legal(input logic [15:0] len, input int max_words);
    return (len != 16'd0) && ({16'd0, len} <= $unsigned(max_words));
  endfunction

endpackage

// File: rtl/xsim_entry_fifo.sv
// First-word-fall-through FIFO of a generic entry type.
// Pointers carry an extra wrap bit so full and empty need no separate counter.
module xsim_entry_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/xsim_msg_deframer.sv
// Splits a raw 32-bit beat stream into framed portal messages (header + payload)
// and presents payload entries through a FWFT FIFO with first/last/empty tags.
module xsim_msg_deframer
  import xsim_msg_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_src_rdy,
  input  logic [31:0] in_beat,
  output logic        in_deq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] out_method,
  output logic        out_first,
  output logic        out_last,
  output logic        out_empty,
  output logic        err_len,
  output logic [31:0] msg_count
);

  deframe_state_t r_state, w_state_nxt;
  logic [15:0]    r_remaining, w_remaining_nxt;
  logic [15:0]    r_method, w_method_nxt;
  logic           r_first_pl, w_first_pl_nxt;
  logic           r_err_len;
  logic [31:0]    r_msg_count;

  logic           w_push, w_msg_inc, w_err_set;
  logic           w_ready, w_len_ok;
  logic           w_full, w_empty, w_pop;
  logic [15:0]    w_len;
  msg_entry_t     w_wr_entry, w_rd_entry;

  assign w_len    = in_beat[HDR_LEN_MSB:0];
  assign w_len_ok = len_legal(w_len, MAX_WORDS);

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_method_nxt    = r_method;
    w_first_pl_nxt  = r_first_pl;
    w_push          = 1'b0;
    w_msg_inc       = 1'b0;
    w_err_set       = 1'b0;
    w_wr_entry      = '0;
    // A malformed header is discarded without touching the FIFO, so it never waits on space.
    w_ready         = !w_full || ((r_state == HDR) && !w_len_ok);
    in_deq          = in_src_rdy && w_ready;

    case (r_state)
      HDR: begin
        if (in_deq) begin
          if (!w_len_ok) begin
            w_err_set = 1'b1;
          end else if (w_len == 16'd1) begin
            w_push            = 1'b1;
            w_msg_inc         = 1'b1;
            w_wr_entry.empty  = 1'b1;
            w_wr_entry.first  = 1'b1;
            w_wr_entry.last   = 1'b1;
            w_wr_entry.method = in_beat[HDR_METHOD_MSB:HDR_METHOD_LSB];
          end else begin
            w_method_nxt    = in_beat[HDR_METHOD_MSB:HDR_METHOD_LSB];
            w_remaining_nxt = w_len - 16'd1;
            w_first_pl_nxt  = 1'b1;
            w_state_nxt     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_deq) begin
          w_push            = 1'b1;
          w_wr_entry.first  = r_first_pl;
          w_wr_entry.last   = (r_remaining == 16'd1);
          w_wr_entry.method = r_method;
          w_wr_entry.data   = in_beat;
          w_remaining_nxt   = r_remaining - 16'd1;
          w_first_pl_nxt    = 1'b0;
          if (r_remaining == 16'd1) begin
            w_msg_inc   = 1'b1;
            w_state_nxt = HDR;
          end
        end
      end
      default: w_state_nxt = HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_method    <= '0;
      r_first_pl  <= 1'b0;
      r_err_len   <= 1'b0;
      r_msg_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_method    <= w_method_nxt;
      r_first_pl  <= w_first_pl_nxt;
      if (w_err_set) r_err_len <= 1'b1;
      if (w_msg_inc) r_msg_count <= r_msg_count + 32'd1;
    end
  end

  xsim_entry_fifo #(
    .DEPTH (DEPTH),
    .T     (msg_entry_t)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (w_push),
    .wdata (w_wr_entry),
    .pop   (w_pop),
    .rdata (w_rd_entry),
    .full  (w_full),
    .empty (w_empty)
  );

  // Outputs are forced to zero when nothing is queued so stale RAM never leaks out.
  assign w_pop      = !w_empty && out_ready;
  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? 32'd0 : w_rd_entry.data;
  assign out_method = w_empty ? 16'd0 : w_rd_entry.method;
  assign out_first  = !w_empty && w_rd_entry.first;
  assign out_last   = !w_empty && w_rd_entry.last;
  assign out_empty  = !w_empty && w_rd_entry.empty;
  assign err_len    = r_err_len;
  assign msg_count  = r_msg_count;

endmodule

// File: tb/tb_xsim_msg_deframer.sv
// Directed bench for xsim_msg_deframer: expected entries are queued as beats are
// driven and compared as the DUT hands them out.
module tb_xsim_msg_deframer;
  import xsim_msg_pkg::*;

  localparam int DEPTH     = 16;
  localparam int MAX_WORDS = 64;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_src_rdy = 1'b0;
  logic [31:0] in_beat = '0;
  logic        in_deq;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] out_method;
  logic        out_first, out_last, out_empty, err_len;
  logic [31:0] msg_count;

  int         n_vec = 0;
  int         n_err = 0;
  msg_entry_t exp_q[$];
  logic       toggle_mode = 1'b0;
  logic       rand_mode = 1'b0;

  xsim_msg_deframer #(.DEPTH(DEPTH), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_src_rdy(in_src_rdy), .in_beat(in_beat),
    .in_deq(in_deq), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_method(out_method), .out_first(out_first),
    .out_last(out_last), .out_empty(out_empty), .err_len(err_len),
    .msg_count(msg_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted output entry must match the oldest expectation.
  always @(negedge CLK) begin
    msg_entry_t e;
    if (RST_N && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_method", 32'(out_method), 32'(e.method));
        check("out_tags", 32'({out_empty, out_first, out_last}), 32'({e.empty, e.first, e.last}));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    in_src_rdy = 1'b1;
    in_beat = b;
    for (int g = 0; g < 500 && !acc; g++) begin
      @(negedge CLK);
      acc = in_deq;
      tick();
    end
    if (!acc) check("send_timeout", 32'd1, 32'd0);
    in_src_rdy = 1'b0;
    if (toggle_mode) tick();
  endtask

  task automatic push_exp(input logic em, input logic f, input logic l,
                          input logic [15:0] m, input logic [31:0] d);
    msg_entry_t e;
    e.empty = em; e.first = f; e.last = l; e.method = m; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_msg(input logic [15:0] m, input int nwords, input logic [31:0] base);
    if (nwords == 0) push_exp(1'b1, 1'b1, 1'b1, m, 32'd0);
    send_beat({m, 16'(nwords + 1)});
    for (int i = 0; i < nwords; i++) begin
      push_exp(1'b0, i == 0, i == nwords - 1, m, base + 32'(i));
      send_beat(base + 32'(i));
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 2000 && exp_q.size() != 0; g++) tick();
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    in_src_rdy = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_deq", 32'(in_deq), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_msg_count", msg_count, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    // Two-word message
    out_ready = 1'b1;
    send_msg(16'h0003, 2, 32'hA);
    drain();
    check("t1_msg_count", msg_count, 32'd1);
    check("t1_err_len", 32'(err_len), 32'd0);

    // Header-only message
    do_reset();
    out_ready = 1'b1;
    send_msg(16'h0007, 0, 32'd0);
    drain();
    check("t2_msg_count", msg_count, 32'd1);

    // Illegal lengths dropped, legal max length accepted
    do_reset();
    out_ready = 1'b1;
    send_beat(32'h0009_0000);
    check("t3_err_len", 32'(err_len), 32'd1);
    check("t3_no_out", 32'(out_valid), 32'd0);
    send_beat(32'h0009_0041);
    check("t3_len65_count", msg_count, 32'd0);
    send_msg(16'h0002, 1, 32'h55);
    drain();
    check("t3_msg_count", msg_count, 32'd1);
    send_msg(16'h0004, MAX_WORDS - 1, 32'h1000);
    drain();
    check("t3_max_count", msg_count, 32'd2);
    check("t3_err_sticky", 32'(err_len), 32'd1);

    // Backpressure: FIFO fills after DEPTH payload beats
    do_reset();
    send_beat(32'h0005_0015);
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(1'b0, i == 0, 1'b0, 16'h0005, 32'h200 + 32'(i));
      send_beat(32'h200 + 32'(i));
    end
    in_src_rdy = 1'b1;
    in_beat = 32'h200 + 32'(DEPTH);
    @(negedge CLK);
    check("t4_deq_full", 32'(in_deq), 32'd0);
    check("t4_valid_full", 32'(out_valid), 32'd1);
    check("t4_count_partial", msg_count, 32'd0);
    tick();
    @(negedge CLK);
    check("t4_deq_held", 32'(in_deq), 32'd0);
    check("t4_data_held", out_data, 32'h200);
    tick();
    out_ready = 1'b1;
    for (int i = DEPTH; i < 20; i++) begin
      push_exp(1'b0, 1'b0, i == 19, 16'h0005, 32'h200 + 32'(i));
      send_beat(32'h200 + 32'(i));
    end
    drain();
    check("t4_msg_count", msg_count, 32'd1);

    // Back-to-back messages, gapped input, random output ready
    do_reset();
    toggle_mode = 1'b1;
    rand_mode = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int lens [5] = '{0, 3, 1, 6, 2};
      send_msg(16'h0010 + 16'(k), lens[k], 32'(k) * 32'h100 + 32'h3000);
      drain();
      check("t5_msg_count", msg_count, 32'(k + 1));
    end
    toggle_mode = 1'b0;
    rand_mode = 1'b0;

    // Reset in the middle of a message
    do_reset();
    send_beat(32'h0008_0006);
    send_beat(32'h400);
    send_beat(32'h401);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    RST_N = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", msg_count, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    out_ready = 1'b1;
    send_msg(16'h0009, 2, 32'h77);
    drain();
    check("t6_msg_count", msg_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
